// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter supporting SLL, SRL, SRA and ROR.
// Operand capture stage p0 is followed by SHAMT_W shift stages. Shift stage k
// moves the word by 2^k when the current low shamt bit is set, then passes the
// remaining shamt bits down. The pipe advances as one unit under a single
// enable, so stalls freeze every entry (including bubbles) in place.
module shift_pipe #(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   // Index 0 is the capture register; indices 1..SHAMT_W-1 hold partially
   // shifted words. The last stage lives in data_out_p/zero_p because it must
   // carry a defined reset value.
   logic [WIDTH-1:0]   data_p  [SHAMT_W];
   logic [SHAMT_W-1:0] shamt_p [SHAMT_W];
   logic [1:0]         op_p    [SHAMT_W];
   logic               sign_p  [SHAMT_W];
   logic               vld_p   [SHAMT_W+1];
   logic [WIDTH-1:0]   shift_c [SHAMT_W];
   logic [WIDTH-1:0]   data_out_p;
   logic               zero_p;
   logic               adv;

   // One fixed-distance step. SRA fill comes from the sign bit captured at
   // accept, so intermediate stages never need to look at their own MSB.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input int               amt,
      input logic [1:0]       op,
      input logic             sign
   );
      logic [WIDTH-1:0] fill;
      fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
      case (op)
         OP_SLL:  shift_step = d << amt;
         OP_SRL:  shift_step = d >> amt;
         OP_SRA:  shift_step = (d >> amt) | fill;
         default: shift_step = (d >> amt) | (d << (WIDTH - amt));
      endcase
   endfunction

   // Whole-pipe advance: move unless a finished result is waiting on the consumer.
   assign adv       = !vld_p[SHAMT_W] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_p[SHAMT_W];
   assign out_data  = data_out_p;
   assign out_zero  = zero_p;

   // Per-stage shifter: stage k consumes bit 0 of its remaining shamt.
   always_comb begin
      for (int k = 0; k < SHAMT_W; k++) begin
         shift_c[k] = shamt_p[k][0] ? shift_step(data_p[k], 1 << k, op_p[k], sign_p[k])
                                    : data_p[k];
      end
   end

   // Control and output stage: valid bits and the visible result are cleared
   // asynchronously so in-flight operands are dropped, never emitted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k <= SHAMT_W; k++) begin
            vld_p[k] <= 1'b0;
         end
         data_out_p <= '0;
         zero_p     <= 1'b0;
      end else if (adv) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k <= SHAMT_W; k++) begin
            vld_p[k] <= vld_p[k-1];
         end
         data_out_p <= shift_c[SHAMT_W-1];
         zero_p     <= (shift_c[SHAMT_W-1] == '0);
      end
   end

   // Datapath stages p0..p(SHAMT_W-1): no reset, bubble contents are don't-care.
   always_ff @(posedge clock) begin
      if (adv) begin
         data_p[0]  <= in_data;
         shamt_p[0] <= in_shamt;
         op_p[0]    <= in_op;
         sign_p[0]  <= in_data[WIDTH-1];
         for (int k = 1; k < SHAMT_W; k++) begin
            data_p[k]  <= shift_c[k-1];
            shamt_p[k] <= shamt_p[k-1] >> 1;
            op_p[k]    <= op_p[k-1];
            sign_p[k]  <= sign_p[k-1];
         end
      end
   end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and randomized bench for shift_pipe at WIDTH 32, 8, 64.
// Each instance has a negedge scoreboard fed by a whole-word reference model.
module tb_shift_pipe;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // WIDTH=32 instance signals
   logic        iv32 = 1'b0, ov32, ir32, or32 = 1'b1, oz32;
   logic [31:0] id32 = '0, od32;
   logic [4:0]  is32 = '0;
   logic [1:0]  io32 = '0;
   // WIDTH=8 instance signals
   logic        iv8 = 1'b0, ov8, ir8, or8 = 1'b1, oz8;
   logic [7:0]  id8 = '0, od8;
   logic [2:0]  is8 = '0;
   logic [1:0]  io8 = '0;
   // WIDTH=64 instance signals
   logic        iv64 = 1'b0, ov64, ir64, or64 = 1'b1, oz64;
   logic [63:0] id64 = '0, od64;
   logic [5:0]  is64 = '0;
   logic [1:0]  io64 = '0;

   shift_pipe #(.WIDTH(32)) dut32 (
      .clock(clock), .reset(reset), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
      .in_shamt(is32), .in_op(io32), .out_valid(ov32), .out_ready(or32),
      .out_data(od32), .out_zero(oz32));
   shift_pipe #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
      .in_shamt(is8), .in_op(io8), .out_valid(ov8), .out_ready(or8),
      .out_data(od8), .out_zero(oz8));
   shift_pipe #(.WIDTH(64)) dut64 (
      .clock(clock), .reset(reset), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
      .in_shamt(is64), .in_op(io64), .out_valid(ov64), .out_ready(or64),
      .out_data(od64), .out_zero(oz64));

   // Reference: shift the whole word by the full amount in one go.
   function automatic logic [63:0] model(input logic [63:0] d, input int s,
                                         input logic [1:0] op, input int w);
      logic [63:0] mask, dm, sx;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      dm   = d & mask;
      sx   = dm[w-1] ? (dm | ~mask) : dm;
      case (op)
         2'b00:   model = (dm << s) & mask;
         2'b01:   model = dm >> s;
         2'b10:   model = 64'($signed(sx) >>> s) & mask;
         default: model = (s == 0) ? dm : (((dm >> s) | (dm << (w - s))) & mask);
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboards: sampled mid-cycle, where handshake signals are settled.
   logic [63:0] q32[$], q8[$], q64[$];
   logic [63:0] e32, e8, e64;
   int pops8 = 0, pops64 = 0;

   always @(negedge clock) begin
      if (!reset) begin
         if (ov32 && or32) begin
            check("sb32_nonempty", 64'(q32.size() != 0), 1);
            if (q32.size() != 0) begin
               e32 = q32.pop_front();
               check("sb32_data", 64'(od32), e32);
               check("sb32_zero", 64'(oz32), 64'(e32 == 0));
            end
         end
         if (iv32 && ir32) q32.push_back(model(64'(id32), int'(is32), io32, 32));
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (ov8 && or8) begin
            check("sb8_nonempty", 64'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
               e8 = q8.pop_front();
               pops8++;
               check("sb8_data", 64'(od8), e8);
               check("sb8_zero", 64'(oz8), 64'(e8 == 0));
            end
         end
         if (iv8 && ir8) q8.push_back(model(64'(id8), int'(is8), io8, 8));
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (ov64 && or64) begin
            check("sb64_nonempty", 64'(q64.size() != 0), 1);
            if (q64.size() != 0) begin
               e64 = q64.pop_front();
               pops64++;
               check("sb64_data", od64, e64);
               check("sb64_zero", 64'(oz64), 64'(e64 == 0));
            end
         end
         if (iv64 && ir64) q64.push_back(model(id64, int'(is64), io64, 64));
      end
   end

   // Directed burst tables for the 32-bit instance.
   logic [31:0] bd [8];
   int          bs [8];
   logic [1:0]  bo [8];
   logic [31:0] be [8];
   logic        bz [8];

   task automatic set_op(input int i, input logic [31:0] d, input int s,
                         input logic [1:0] o, input logic [31:0] e);
      bd[i] = d; bs[i] = s; bo[i] = o; be[i] = e; bz[i] = (e == 0);
   endtask

   // Issue n operands back-to-back and expect each exactly 5 edges after accept.
   task automatic run_burst(input int n);
      or32 = 1'b1;
      for (int c = 0; c < n + 5; c++) begin
         if (c < n) begin
            iv32 = 1'b1; id32 = bd[c]; is32 = 5'(bs[c]); io32 = bo[c];
            #1 check("burst_in_ready", 64'(ir32), 1);
         end else begin
            iv32 = 1'b0;
         end
         tick();
         if (c >= 5) begin
            check("burst_valid", 64'(ov32), 1);
            check("burst_data", 64'(od32), 64'(be[c-5]));
            check("burst_zero", 64'(oz32), 64'(bz[c-5]));
         end else begin
            check("burst_latency_idle", 64'(ov32), 0);
         end
      end
      iv32 = 1'b0;
   endtask

   logic [31:0] bp_d [8];
   int          bp_s [8];
   logic [1:0]  bp_o [8];
   logic [31:0] bp_e [8];
   int          next_in, next_out, stall_cnt, cyc;
   logic        seen, acc, xfer;

   initial begin
      // Reset values
      #1 reset = 1'b1;
      #1;
      check("rst_out_valid", 64'(ov32), 0);
      check("rst_out_data", 64'(od32), 0);
      check("rst_out_zero", 64'(oz32), 0);
      @(posedge clock); #2 reset = 1'b0;
      tick();
      check("rst_in_ready", 64'(ir32), 1);

      // SLL to the top bit
      set_op(0, 32'h0000_0001, 31, 2'b00, 32'h8000_0000);
      run_burst(1);

      // SRL vs SRA back-to-back
      set_op(0, 32'h8000_0000, 4, 2'b01, 32'h0800_0000);
      set_op(1, 32'h8000_0000, 4, 2'b10, 32'hF800_0000);
      run_burst(2);

      // Shamt 0 in every mode returns the operand
      set_op(0, 32'hA5C3_0F96, 0, 2'b00, 32'hA5C3_0F96);
      set_op(1, 32'h8001_2345, 0, 2'b01, 32'h8001_2345);
      set_op(2, 32'hF000_000F, 0, 2'b10, 32'hF000_000F);
      set_op(3, 32'h1357_9BDF, 0, 2'b11, 32'h1357_9BDF);
      run_burst(4);

      // Rotates, plus a zero result
      set_op(0, 32'h0000_0001, 1, 2'b11, 32'h8000_0000);
      set_op(1, 32'h1234_5678, 8, 2'b11, 32'h7812_3456);
      set_op(2, 32'hFFFF_FFFF, 31, 2'b00, 32'h8000_0000);
      set_op(3, 32'h0000_0001, 1, 2'b01, 32'h0000_0000);
      run_burst(4);

      // Backpressure: 8 operands, output held after the first result
      tick();
      for (int i = 0; i < 8; i++) begin
         bp_d[i] = $urandom;
         bp_s[i] = $urandom_range(31);
         bp_o[i] = 2'($urandom);
         bp_e[i] = 32'(model(64'(bp_d[i]), bp_s[i], bp_o[i], 32));
      end
      next_in = 0; next_out = 0; stall_cnt = 0; cyc = 0; seen = 1'b0;
      while (next_out < 8 && cyc < 200) begin
         if (ov32) seen = 1'b1;
         or32 = !(seen && stall_cnt < 6);
         iv32 = (next_in < 8);
         if (next_in < 8) begin
            id32 = bp_d[next_in]; is32 = 5'(bp_s[next_in]); io32 = bp_o[next_in];
         end
         #1;
         if (!or32) begin
            check("bp_hold_valid", 64'(ov32), 1);
            check("bp_hold_data", 64'(od32), 64'(bp_e[0]));
            check("bp_stall_in_ready", 64'(ir32), 0);
            stall_cnt++;
         end
         acc  = iv32 && ir32;
         xfer = ov32 && or32;
         if (xfer) check("bp_order", 64'(od32), 64'(bp_e[next_out]));
         tick();
         if (acc) next_in++;
         if (xfer) next_out++;
         cyc++;
      end
      iv32 = 1'b0; or32 = 1'b1;
      check("bp_all_out", 64'(next_out), 8);
      check("bp_stalled", 64'(stall_cnt), 6);

      // Reset while a result is held on the output: drops asynchronously
      tick();
      or32 = 1'b0;
      iv32 = 1'b1; id32 = 32'h0F0F_0001; is32 = 5'd3; io32 = 2'b00;
      tick();
      iv32 = 1'b0;
      cyc = 0;
      while (!ov32 && cyc < 20) begin tick(); cyc++; end
      check("rstA_reached_out", 64'(ov32), 1);
      #2 reset = 1'b1;
      q32.delete(); q8.delete(); q64.delete();
      #1;
      check("rstA_async_valid", 64'(ov32), 0);
      check("rstA_async_data", 64'(od32), 0);
      check("rstA_async_zero", 64'(oz32), 0);
      @(posedge clock); #2 reset = 1'b0;
      tick();
      check("rstA_in_ready", 64'(ir32), 1);

      // Reset mid-flight with three operands in the pipe
      or32 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iv32 = 1'b1; id32 = 32'hFFFF_0000 >> i; is32 = 5'(i + 1); io32 = 2'b01;
         tick();
      end
      iv32 = 1'b0;
      tick();
      #2 reset = 1'b1;
      q32.delete(); q8.delete(); q64.delete();
      #1 check("rstB_async_valid", 64'(ov32), 0);
      @(posedge clock); #2 reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rstB_no_ghost", 64'(ov32), 0);
      end
      set_op(0, 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
      run_burst(1);

      // Random regression on all three widths
      for (int c = 0; c < 3000; c++) begin
         iv8  = ($urandom_range(3) != 0); id8  = 8'($urandom);        is8  = 3'($urandom);
         io8  = 2'($urandom);             or8  = ($urandom_range(3) != 0);
         iv64 = ($urandom_range(3) != 0); id64 = {$urandom, $urandom}; is64 = 6'($urandom);
         io64 = 2'($urandom);             or64 = ($urandom_range(3) != 0);
         iv32 = ($urandom_range(3) != 0); id32 = $urandom;            is32 = 5'($urandom);
         io32 = 2'($urandom);             or32 = ($urandom_range(3) != 0);
         tick();
      end
      iv8 = 1'b0; iv64 = 1'b0; iv32 = 1'b0;
      or8 = 1'b1; or64 = 1'b1; or32 = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("rand8_drained", 64'(q8.size()), 0);
      check("rand64_drained", 64'(q64.size()), 0);
      check("rand32_drained", 64'(q32.size()), 0);
      check("rand8_progress", 64'(pops8 > 500), 1);
      check("rand64_progress", 64'(pops64 > 500), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
